byteblast8_boot_ctrl: RTL and testbench

//  Sequencer wrapping the byteblast8 core: streams a program image into core RAM, raises
//  cpu enable, detects halt (opcode 0 held HALT_CYCLES clocks), then offers host readback
//  of RAM. Owns the RAM port except while the core runs. Replaces host-side RAM poking.

---
 rtl/byteblast8_pkg.sv | 13 +
 rtl/byteblast8_if.sv | 39 +++
 rtl/byteblast8_halt_detect.sv | 46 ++++
 rtl/byteblast8_boot_ctrl.sv | 152 +++++++++++++++
 tb/tb_byteblast8_boot_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/byteblast8_pkg.sv
// Shared types and constants for the byteblast8 boot sequencer.
package byteblast8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned HALT_OPCODE = 0;

endpackage

// File: rtl/byteblast8_if.sv
// Host / RAM / core signal bundle around the boot controller.
interface byteblast8_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 3
);
  logic               start;
  logic               load_valid;
  logic [7:0]         load_data;
  logic               load_last;
  logic               load_ready;
  logic               mem_own;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [7:0]         ram_wdata;
  logic [7:0]         ram_rdata;
  logic               cpu_enable;
  logic [INSTR_W-1:0] cpu_instr;
  logic               rd_req;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_valid;
  logic [7:0]         rd_data;
  logic               busy;
  logic               done;
  logic               err_ovf;
  logic               err_tmo;
  logic [31:0]        cycles;

  modport slave (
    input  start, load_valid, load_data, load_last, ram_rdata, cpu_instr, rd_req, rd_addr,
    output load_ready, mem_own, ram_we, ram_addr, ram_wdata, cpu_enable, rd_valid, rd_data,
    output busy, done, err_ovf, err_tmo, cycles
  );

  modport master (
    output start, load_valid, load_data, load_last, ram_rdata, cpu_instr, rd_req, rd_addr,
    input  load_ready, mem_own, ram_we, ram_addr, ram_wdata, cpu_enable, rd_valid, rd_data,
    input  busy, done, err_ovf, err_tmo, cycles
  );
endinterface

// File: rtl/byteblast8_halt_detect.sv
// Counts consecutive halt opcodes while the core runs; flags halt on the
// clock that completes HALT_CYCLES in a row.
module byteblast8_halt_detect
  import byteblast8_pkg::*;
#(
  parameter int INSTR_W     = 3,
  parameter int HALT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               halt_o
);

  localparam int CNT_W = $clog2(HALT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             is_halt_s;
  logic             at_limit_s;

  assign is_halt_s  = (instr_i == INSTR_W'(HALT_OPCODE));
  assign at_limit_s = (cnt_q == CNT_W'(HALT_CYCLES - 1));
  assign halt_o     = en_i && is_halt_s && at_limit_s;

  // Run-length counter of halt opcodes, stalls at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (!is_halt_s) begin
        cnt_q <= '0;
      end else if (!at_limit_s) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= cnt_q;
      end
    end else begin
      cnt_q <= cnt_q;
    end
  end

endmodule

// File: rtl/byteblast8_boot_ctrl.sv
// Boot sequencer: streams an image into core RAM, runs the core until halt or
// watchdog, then serves host readback of RAM.
module byteblast8_boot_ctrl
  import byteblast8_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int INSTR_W     = 3,
  parameter int HALT_CYCLES = 4,
  parameter int MAX_CYCLES  = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  byteblast8_if.slave  bus
);

  state_e              state_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [7:0]          ram_wdata_q;
  logic [31:0]         cycles_q;
  logic                load_ready_q, mem_own_q, ram_we_q, cpu_enable_q;
  logic                rd_pend_q, rd_valid_q, busy_q, done_q, err_ovf_q, err_tmo_q;

  logic                start_ok_s, accept_s, run_tick_s, halt_s, tmo_s;
  logic [31:0]         cycles_inc_s;

  // The core only counts as running once cpu_enable is visible; the first RUN
  // clock hands the RAM port over and lets the final image write complete.
  always_comb begin
    start_ok_s   = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    accept_s     = bus.load_valid && load_ready_q;
    run_tick_s   = (state_q == ST_RUN) && cpu_enable_q;
    cycles_inc_s = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : (cycles_q + 32'd1);
    tmo_s        = (MAX_CYCLES != 0) && (cycles_inc_s == 32'(MAX_CYCLES));
  end

  byteblast8_halt_detect #(
    .INSTR_W     (INSTR_W),
    .HALT_CYCLES (HALT_CYCLES)
  ) u_halt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (run_tick_s),
    .clr_i   (!run_tick_s),
    .instr_i (bus.cpu_instr),
    .halt_o  (halt_s)
  );

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= 8'h00;
      cycles_q     <= 32'd0;
      load_ready_q <= 1'b0;
      mem_own_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      cpu_enable_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_tmo_q    <= 1'b0;
    end else begin
      ram_we_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= rd_pend_q;
      if (start_ok_s) begin
        state_q      <= ST_LOAD;
        wr_ptr_q     <= '0;
        cycles_q     <= 32'd0;
        load_ready_q <= 1'b1;
        mem_own_q    <= 1'b1;
        busy_q       <= 1'b1;
        done_q       <= 1'b0;
        err_ovf_q    <= 1'b0;
        err_tmo_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_IDLE;
          ST_LOAD: begin
            if (accept_s) begin
              ram_we_q    <= 1'b1;
              ram_addr_q  <= wr_ptr_q;
              ram_wdata_q <= bus.load_data;
              wr_ptr_q    <= wr_ptr_q + ADDR_W'(1);
              if (bus.load_last) begin
                state_q      <= ST_RUN;
                load_ready_q <= 1'b0;
              end else if (wr_ptr_q == '1) begin
                state_q      <= ST_DONE;
                load_ready_q <= 1'b0;
                busy_q       <= 1'b0;
                done_q       <= 1'b1;
                err_ovf_q    <= 1'b1;
              end else begin
                state_q <= ST_LOAD;
              end
            end else begin
              state_q <= ST_LOAD;
            end
          end
          ST_RUN: begin
            if (!cpu_enable_q) begin
              cpu_enable_q <= 1'b1;
              mem_own_q    <= 1'b0;
            end else begin
              cycles_q <= cycles_inc_s;
              if (halt_s || tmo_s) begin
                state_q      <= ST_DONE;
                cpu_enable_q <= 1'b0;
                mem_own_q    <= 1'b1;
                busy_q       <= 1'b0;
                done_q       <= 1'b1;
                err_tmo_q    <= !halt_s;
              end else begin
                state_q <= ST_RUN;
              end
            end
          end
          ST_DONE: begin
            if (bus.rd_req) begin
              ram_addr_q <= bus.rd_addr;
              rd_pend_q  <= 1'b1;
            end else begin
              ram_addr_q <= ram_addr_q;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.mem_own    = mem_own_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.cpu_enable = cpu_enable_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_valid_q ? bus.ram_rdata : 8'h00;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err_ovf    = err_ovf_q;
  assign bus.err_tmo    = err_tmo_q;
  assign bus.cycles     = cycles_q;

endmodule

// File: tb/tb_byteblast8_boot_ctrl.sv
// Directed bench: dut_a (8-bit RAM, no watchdog) runs a vector table;
// dut_b (16-byte RAM, watchdog 10) covers overflow and timeout corners.
module tb_byteblast8_boot_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  byteblast8_if #(.ADDR_W(8), .INSTR_W(3)) ifa ();
  byteblast8_if #(.ADDR_W(4), .INSTR_W(3)) ifb ();

  byteblast8_boot_ctrl #(.ADDR_W(8), .INSTR_W(3), .HALT_CYCLES(4), .MAX_CYCLES(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  byteblast8_boot_ctrl #(.ADDR_W(4), .INSTR_W(3), .HALT_CYCLES(4), .MAX_CYCLES(10))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [16];
  int         writes_b = 0;
  logic       en_seen_b = 1'b0;

  // Synchronous RAM models: one clock read latency, write only while controller owns the port.
  always @(posedge clk) begin
    if (ifa.ram_we && ifa.mem_own) mem_a[ifa.ram_addr] <= ifa.ram_wdata;
    ifa.ram_rdata <= mem_a[ifa.ram_addr];
    if (ifb.ram_we && ifb.mem_own) begin
      mem_b[ifb.ram_addr] <= ifb.ram_wdata;
      writes_b <= writes_b + 1;
    end
    ifb.ram_rdata <= mem_b[ifb.ram_addr];
    if (ifb.cpu_enable) en_seen_b <= 1'b1;
  end

  typedef struct {
    logic st, lv; logic [7:0] ld; logic ll; logic [2:0] ins; logic rq; logic [7:0] ra;
    logic lr, mo, we; logic [7:0] addr, wd; logic ce, dn, bz, rv; logic [7:0] rdd;
    logic [31:0] cyc;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Inputs: st lv ld ll ins rq ra | lr mo we addr wd ce dn bz rv rdd cyc
    vecs[0]  = '{1'b1,1'b0,8'h00,1'b0,3'd0,1'b0,8'h00, 1'b1,1'b1,1'b0,8'h00,8'h00,1'b0,1'b0,1'b1,1'b0,8'h00,32'd0};
    vecs[1]  = '{1'b0,1'b1,8'h12,1'b0,3'd0,1'b0,8'h00, 1'b1,1'b1,1'b1,8'h00,8'h12,1'b0,1'b0,1'b1,1'b0,8'h00,32'd0};
    vecs[2]  = '{1'b0,1'b1,8'h34,1'b0,3'd0,1'b0,8'h00, 1'b1,1'b1,1'b1,8'h01,8'h34,1'b0,1'b0,1'b1,1'b0,8'h00,32'd0};
    vecs[3]  = '{1'b0,1'b1,8'h56,1'b1,3'd0,1'b0,8'h00, 1'b0,1'b1,1'b1,8'h02,8'h56,1'b0,1'b0,1'b1,1'b0,8'h00,32'd0};
    vecs[4]  = '{1'b0,1'b0,8'h00,1'b0,3'd5,1'b0,8'h00, 1'b0,1'b0,1'b0,8'h02,8'h56,1'b1,1'b0,1'b1,1'b0,8'h00,32'd0};
    vecs[5]  = '{1'b0,1'b0,8'h00,1'b0,3'd0,1'b0,8'h00, 1'b0,1'b0,1'b0,8'h02,8'h56,1'b1,1'b0,1'b1,1'b0,8'h00,32'd1};
    vecs[6]  = '{1'b0,1'b0,8'h00,1'b0,3'd0,1'b0,8'h00, 1'b0,1'b0,1'b0,8'h02,8'h56,1'b1,1'b0,1'b1,1'b0,8'h00,32'd2};
    vecs[7]  = '{1'b0,1'b0,8'h00,1'b0,3'd0,1'b0,8'h00, 1'b0,1'b0,1'b0,8'h02,8'h56,1'b1,1'b0,1'b1,1'b0,8'h00,32'd3};
    vecs[8]  = '{1'b0,1'b0,8'h00,1'b0,3'd5,1'b0,8'h00, 1'b0,1'b0,1'b0,8'h02,8'h56,1'b1,1'b0,1'b1,1'b0,8'h00,32'd4};
    vecs[9]  = '{1'b0,1'b0,8'h00,1'b0,3'd0,1'b0,8'h00, 1'b0,1'b0,1'b0,8'h02,8'h56,1'b1,1'b0,1'b1,1'b0,8'h00,32'd5};
    vecs[10] = '{1'b0,1'b0,8'h00,1'b0,3'd0,1'b0,8'h00, 1'b0,1'b0,1'b0,8'h02,8'h56,1'b1,1'b0,1'b1,1'b0,8'h00,32'd6};
    vecs[11] = '{1'b0,1'b0,8'h00,1'b0,3'd0,1'b0,8'h00, 1'b0,1'b0,1'b0,8'h02,8'h56,1'b1,1'b0,1'b1,1'b0,8'h00,32'd7};
    vecs[12] = '{1'b0,1'b0,8'h00,1'b0,3'd0,1'b0,8'h00, 1'b0,1'b1,1'b0,8'h02,8'h56,1'b0,1'b1,1'b0,1'b0,8'h00,32'd8};
    vecs[13] = '{1'b0,1'b0,8'h00,1'b0,3'd0,1'b1,8'h01, 1'b0,1'b1,1'b0,8'h01,8'h56,1'b0,1'b1,1'b0,1'b0,8'h00,32'd8};
    vecs[14] = '{1'b0,1'b0,8'h00,1'b0,3'd0,1'b1,8'h02, 1'b0,1'b1,1'b0,8'h02,8'h56,1'b0,1'b1,1'b0,1'b1,8'h34,32'd8};
    vecs[15] = '{1'b0,1'b0,8'h00,1'b0,3'd0,1'b1,8'h00, 1'b0,1'b1,1'b0,8'h00,8'h56,1'b0,1'b1,1'b0,1'b1,8'h56,32'd8};
    vecs[16] = '{1'b1,1'b0,8'h00,1'b0,3'd0,1'b1,8'h01, 1'b1,1'b1,1'b0,8'h00,8'h56,1'b0,1'b0,1'b1,1'b1,8'h12,32'd0};
    vecs[17] = '{1'b0,1'b0,8'h00,1'b0,3'd0,1'b1,8'h01, 1'b1,1'b1,1'b0,8'h00,8'h56,1'b0,1'b0,1'b1,1'b0,8'h00,32'd0};
    vecs[18] = '{1'b0,1'b1,8'hAB,1'b1,3'd0,1'b0,8'h00, 1'b0,1'b1,1'b1,8'h00,8'hAB,1'b0,1'b0,1'b1,1'b0,8'h00,32'd0};
    vecs[19] = '{1'b0,1'b0,8'h00,1'b0,3'd3,1'b0,8'h00, 1'b0,1'b0,1'b0,8'h00,8'hAB,1'b1,1'b0,1'b1,1'b0,8'h00,32'd0};

    {ifa.start, ifa.load_valid, ifa.load_data, ifa.load_last, ifa.cpu_instr, ifa.rd_req, ifa.rd_addr} = '0;
    {ifb.start, ifb.load_valid, ifb.load_data, ifb.load_last, ifb.cpu_instr, ifb.rd_req, ifb.rd_addr} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(ifa.busy), 32'd0);
    chk("reset mem_own", 32'(ifa.mem_own), 32'd0);
    chk("reset cpu_enable", 32'(ifa.cpu_enable), 32'd0);
    chk("reset load_ready", 32'(ifa.load_ready), 32'd0);
    chk("reset rd_valid", 32'(ifa.rd_valid), 32'd0);
    chk("reset cycles", ifa.cycles, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      ifa.start = vecs[i].st;     ifa.load_valid = vecs[i].lv; ifa.load_data = vecs[i].ld;
      ifa.load_last = vecs[i].ll; ifa.cpu_instr = vecs[i].ins; ifa.rd_req = vecs[i].rq;
      ifa.rd_addr = vecs[i].ra;
      tick();
      chk($sformatf("row%0d load_ready", i), 32'(ifa.load_ready), 32'(vecs[i].lr));
      chk($sformatf("row%0d mem_own", i),    32'(ifa.mem_own),    32'(vecs[i].mo));
      chk($sformatf("row%0d ram_we", i),     32'(ifa.ram_we),     32'(vecs[i].we));
      chk($sformatf("row%0d ram_addr", i),   32'(ifa.ram_addr),   32'(vecs[i].addr));
      chk($sformatf("row%0d ram_wdata", i),  32'(ifa.ram_wdata),  32'(vecs[i].wd));
      chk($sformatf("row%0d cpu_enable", i), 32'(ifa.cpu_enable), 32'(vecs[i].ce));
      chk($sformatf("row%0d done", i),       32'(ifa.done),       32'(vecs[i].dn));
      chk($sformatf("row%0d busy", i),       32'(ifa.busy),       32'(vecs[i].bz));
      chk($sformatf("row%0d rd_valid", i),   32'(ifa.rd_valid),   32'(vecs[i].rv));
      chk($sformatf("row%0d rd_data", i),    32'(ifa.rd_data),    32'(vecs[i].rdd));
      chk($sformatf("row%0d cycles", i),     ifa.cycles,          vecs[i].cyc);
    end

    // Asynchronous reset mid-RUN, then a clean reload.
    {ifa.start, ifa.load_valid, ifa.load_last, ifa.rd_req} = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst cpu_enable", 32'(ifa.cpu_enable), 32'd0);
    chk("async rst busy", 32'(ifa.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    chk("reload load_ready", 32'(ifa.load_ready), 32'd1);
    chk("reload cycles", ifa.cycles, 32'd0);
    ifa.load_valid = 1'b1; ifa.load_data = 8'h77; ifa.load_last = 1'b1;
    tick();
    ifa.load_valid = 1'b0; ifa.load_last = 1'b0; ifa.cpu_instr = 3'd2;
    chk("reload ram_we", 32'(ifa.ram_we), 32'd1);
    chk("reload ram_addr", 32'(ifa.ram_addr), 32'd0);
    tick();
    chk("reload cpu_enable", 32'(ifa.cpu_enable), 32'd1);
    chk("reload mem0", 32'(mem_a[0]), 32'h77);

    // Overflow: 17 bytes into a 16-byte RAM without load_last.
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      ifb.load_valid = 1'b1; ifb.load_data = 8'(i);
      tick();
    end
    ifb.load_valid = 1'b0;
    tick(); tick();
    chk("ovf writes", 32'(writes_b), 32'd16);
    chk("ovf err_ovf", 32'(ifb.err_ovf), 32'd1);
    chk("ovf done", 32'(ifb.done), 32'd1);
    chk("ovf busy", 32'(ifb.busy), 32'd0);
    chk("ovf cpu never enabled", 32'(en_seen_b), 32'd0);
    chk("ovf mem15", 32'(mem_b[15]), 32'h0F);

    // Watchdog: opcode never 0.
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    chk("tmo entry clears err_ovf", 32'(ifb.err_ovf), 32'd0);
    ifb.load_valid = 1'b1; ifb.load_data = 8'h01; ifb.load_last = 1'b1;
    tick();
    ifb.load_valid = 1'b0; ifb.load_last = 1'b0; ifb.cpu_instr = 3'd1;
    for (int k = 0; k < 40 && !ifb.done; k++) tick();
    chk("tmo done", 32'(ifb.done), 32'd1);
    chk("tmo err_tmo", 32'(ifb.err_tmo), 32'd1);
    chk("tmo cycles", ifb.cycles, 32'd10);
    chk("tmo cpu_enable", 32'(ifb.cpu_enable), 32'd0);

    // Halt completes on the same clock the watchdog would fire.
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    chk("halt+tmo entry clears err_tmo", 32'(ifb.err_tmo), 32'd0);
    ifb.load_valid = 1'b1; ifb.load_last = 1'b1;
    tick();
    ifb.load_valid = 1'b0; ifb.load_last = 1'b0; ifb.cpu_instr = 3'd1;
    tick();
    for (int k = 1; k <= 10; k++) begin
      ifb.cpu_instr = (k >= 7) ? 3'd0 : 3'd1;
      if (k == 10) chk("halt+tmo not early", 32'(ifb.done), 32'd0);
      tick();
    end
    chk("halt+tmo done", 32'(ifb.done), 32'd1);
    chk("halt+tmo err_tmo", 32'(ifb.err_tmo), 32'd0);
    chk("halt+tmo cycles", ifb.cycles, 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
